// File: rtl/sync_down_timer_if.sv
// Control/status bundle for sync_down_timer: load/start/stop requests in,
// count/busy/tc status out.
interface sync_down_timer_if #(
  parameter int WIDTH = 4,
  parameter int PRE_W = 8
);
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             start;
  logic             stop;
  logic             auto_reload;
  logic [PRE_W-1:0] prescale;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             tc;

  modport master (
    output load, load_val, start, stop, auto_reload, prescale,
    input  count, busy, tc
  );

  modport slave (
    input  load, load_val, start, stop, auto_reload, prescale,
    output count, busy, tc
  );
endinterface

// File: rtl/sync_down_timer.sv
// Loadable prescaled down-timer with one-shot / auto-reload modes and pause/resume.
// tc is a one-cycle registered pulse on expiry, or on a start with nothing loaded.
module sync_down_timer #(
  parameter int WIDTH = 4,
  parameter int PRE_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  sync_down_timer_if.slave  bus
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] count, count_n;
  logic [WIDTH-1:0] reload_reg, reload_n;
  logic [PRE_W-1:0] pre_cnt, pre_cnt_n;
  logic [PRE_W-1:0] pre_lat, pre_lat_n;
  logic             busy, busy_n;
  logic             tc, tc_n;
  logic             tick;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      count      <= '0;
      reload_reg <= '0;
      pre_cnt    <= '0;
      pre_lat    <= '0;
      busy       <= 1'b0;
      tc         <= 1'b0;
    end else begin
      state      <= state_n;
      count      <= count_n;
      reload_reg <= reload_n;
      pre_cnt    <= pre_cnt_n;
      pre_lat    <= pre_lat_n;
      busy       <= busy_n;
      tc         <= tc_n;
    end
  end

  assign tick = (pre_cnt == pre_lat);

  // Priority on every edge: stop, then load, then start.
  always_comb begin
    state_n   = state;
    count_n   = count;
    reload_n  = reload_reg;
    pre_cnt_n = pre_cnt;
    pre_lat_n = pre_lat;
    busy_n    = busy;
    tc_n      = 1'b0;

    case (state)
      IDLE: begin
        if (bus.stop) begin
          state_n = IDLE;
        end else if (bus.load) begin
          reload_n = bus.load_val;
          count_n  = bus.load_val;
        end else if (bus.start) begin
          if (count != '0) begin
            state_n   = RUN;
            busy_n    = 1'b1;
            pre_cnt_n = '0;
            pre_lat_n = bus.prescale;
          end else begin
            tc_n = 1'b1;
          end
        end
      end

      RUN: begin
        if (bus.stop) begin
          state_n = IDLE;
          busy_n  = 1'b0;
        end else begin
          if (bus.load) begin
            reload_n = bus.load_val;
          end
          pre_cnt_n = tick ? '0 : pre_cnt + 1'b1;
          if (tick) begin
            if (count > WIDTH'(1)) begin
              count_n = count - 1'b1;
            end else if (count == WIDTH'(1)) begin
              tc_n = 1'b1;
              if (bus.auto_reload && (reload_reg != '0)) begin
                count_n   = reload_reg;
                pre_cnt_n = '0;
              end else begin
                count_n = '0;
                state_n = IDLE;
                busy_n  = 1'b0;
              end
            end else begin
              // Unreachable in normal use; drop back to IDLE rather than wrap.
              state_n = IDLE;
              busy_n  = 1'b0;
            end
          end
        end
      end

      default: begin
        state_n = IDLE;
        busy_n  = 1'b0;
      end
    endcase
  end

  assign bus.count = count;
  assign bus.busy  = busy;
  assign bus.tc    = tc;

endmodule

// File: tb/tb_sync_down_timer.sv
// Directed bench for sync_down_timer: one-shot, auto-reload, pause/resume,
// simultaneous events, zero-count start, full-range load and mid-run reset.
module tb_sync_down_timer;

  localparam int WIDTH = 4;
  localparam int PRE_W = 8;

  logic clk;
  logic rst;
  int   checkCount;
  int   failCount;

  sync_down_timer_if #(.WIDTH(WIDTH), .PRE_W(PRE_W)) bus ();

  sync_down_timer #(.WIDTH(WIDTH), .PRE_W(PRE_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checkCount++;
    if (observed != expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic checkState(input string tag, input int expCount, input int expBusy, input int expTc);
    checkOutput({tag, ".count"}, int'(bus.count), expCount);
    checkOutput({tag, ".busy"}, int'(bus.busy), expBusy);
    checkOutput({tag, ".tc"}, int'(bus.tc), expTc);
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic stepClk();
    @(posedge clk);
    #1;
  endtask

  // Present one-cycle request pulses for a single edge, then release them.
  task automatic applyStimulus(input logic ld, input int lv, input logic st, input logic sp);
    bus.load     = ld;
    bus.load_val = WIDTH'(lv);
    bus.start    = st;
    bus.stop     = sp;
    stepClk();
    bus.load  = 1'b0;
    bus.start = 1'b0;
    bus.stop  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    checkCount       = 0;
    failCount        = 0;
    rst              = 1'b1;
    bus.load         = 1'b0;
    bus.load_val     = '0;
    bus.start        = 1'b0;
    bus.stop         = 1'b0;
    bus.auto_reload  = 1'b0;
    bus.prescale     = '0;

    stepClk();
    stepClk();
    checkState("reset", 0, 0, 0);
    rst = 1'b0;

    // One-shot, prescale 0, load 5
    applyStimulus(1'b1, 5, 1'b0, 1'b0);
    checkState("t1.load", 5, 0, 0);
    applyStimulus(1'b0, 0, 1'b1, 1'b0);
    checkState("t1.start", 5, 1, 0);
    for (int i = 4; i >= 0; i--) begin
      stepClk();
      checkState($sformatf("t1.run%0d", i), i, (i != 0) ? 1 : 0, (i == 0) ? 1 : 0);
    end
    stepClk();
    checkState("t1.after", 0, 0, 0);

    // Auto-reload, prescale 2, load 3: period 9 clocks
    bus.prescale    = 8'd2;
    bus.auto_reload = 1'b1;
    applyStimulus(1'b1, 3, 1'b0, 1'b0);
    applyStimulus(1'b0, 0, 1'b1, 1'b0);
    checkState("t2.start", 3, 1, 0);
    for (int k = 1; k <= 18; k++) begin
      stepClk();
      checkState($sformatf("t2.ar%0d", k), 3 - ((k / 3) % 3), 1, (k % 9 == 0) ? 1 : 0);
    end
    bus.auto_reload = 1'b0;
    for (int k = 19; k <= 27; k++) begin
      stepClk();
      if (k < 27)
        checkState($sformatf("t2.os%0d", k), 3 - ((k / 3) % 3), 1, 0);
      else
        checkState("t2.expire", 0, 0, 1);
    end

    // Pause at 7 and resume
    bus.prescale = 8'd0;
    applyStimulus(1'b1, 10, 1'b0, 1'b0);
    applyStimulus(1'b0, 0, 1'b1, 1'b0);
    checkState("t3.start", 10, 1, 0);
    for (int i = 9; i >= 7; i--) begin
      stepClk();
      checkState($sformatf("t3.run%0d", i), i, 1, 0);
    end
    applyStimulus(1'b0, 0, 1'b0, 1'b1);
    checkState("t3.stop", 7, 0, 0);
    for (int i = 0; i < 5; i++) begin
      stepClk();
      checkState($sformatf("t3.hold%0d", i), 7, 0, 0);
    end
    applyStimulus(1'b0, 0, 1'b1, 1'b0);
    checkState("t3.resume", 7, 1, 0);
    for (int i = 6; i >= 0; i--) begin
      stepClk();
      checkState($sformatf("t3.run%0d", i), i, (i != 0) ? 1 : 0, (i == 0) ? 1 : 0);
    end

    // Load and start together in IDLE: only the load lands
    applyStimulus(1'b1, 6, 1'b1, 1'b0);
    checkState("t4.ldst", 6, 0, 0);
    stepClk();
    checkState("t4.ldst_idle", 6, 0, 0);

    // Stop coinciding with the expiry tick
    applyStimulus(1'b0, 0, 1'b1, 1'b0);
    checkState("t4.start", 6, 1, 0);
    for (int i = 5; i >= 1; i--) begin
      stepClk();
      checkState($sformatf("t4.run%0d", i), i, 1, 0);
    end
    applyStimulus(1'b0, 0, 1'b0, 1'b1);
    checkState("t4.stop_tick", 1, 0, 0);
    applyStimulus(1'b0, 0, 1'b1, 1'b0);
    checkState("t4.resume", 1, 1, 0);
    stepClk();
    checkState("t4.expire", 0, 0, 1);

    // Start with count 0: lone tc pulse, busy stays low
    applyStimulus(1'b0, 0, 1'b1, 1'b0);
    checkState("t5.zero_start", 0, 0, 1);
    stepClk();
    checkState("t5.zero_after", 0, 0, 0);

    // Full-range load 15
    applyStimulus(1'b1, 15, 1'b0, 1'b0);
    applyStimulus(1'b0, 0, 1'b1, 1'b0);
    checkState("t5.start15", 15, 1, 0);
    for (int k = 1; k <= 15; k++) begin
      stepClk();
      checkState($sformatf("t5.run%0d", 15 - k), 15 - k, (k != 15) ? 1 : 0, (k == 15) ? 1 : 0);
    end
    stepClk();
    checkState("t5.nowrap", 0, 0, 0);

    // Load in RUN only updates the reload value
    bus.auto_reload = 1'b1;
    applyStimulus(1'b1, 2, 1'b0, 1'b0);
    applyStimulus(1'b0, 0, 1'b1, 1'b0);
    applyStimulus(1'b1, 4, 1'b0, 1'b0);
    checkState("t5.ld_run", 1, 1, 0);
    stepClk();
    checkState("t5.reload4", 4, 1, 1);
    bus.auto_reload = 1'b0;

    // Reset mid-run at count 4 (counting 4,3,... from the reload above)
    rst = 1'b1;
    stepClk();
    checkState("t6.rst", 0, 0, 0);
    rst = 1'b0;
    applyStimulus(1'b0, 0, 1'b1, 1'b0);
    checkState("t6.zero_start", 0, 0, 1);
    stepClk();
    checkState("t6.after", 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
